// File: rtl/rotate2_frame_writer.sv
// Write side of the ping-pong rotated frame buffer.
// Turns a valid-qualified 1-bit raster pixel stream into BRAM writes at
// address = bank_base + y*COLS + x. The row/column product comes from a
// running linear counter, so no multiplier is needed. Banks swap only after
// a complete frame has been written.
module rotate2_frame_writer #(
  parameter int COLS        = 80,
  parameter int ROWS        = 107,
  parameter int BANK_OFFSET = 16384
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        frame_start_in,
  input  logic        data_valid_in,
  input  logic        pixel_in,
  output logic        pixel_out,
  output logic [16:0] pixel_addr_out,
  output logic        write_en_out,
  output logic        bank_out,
  output logic        frame_done_out,
  output logic        frame_error_out
);

  localparam int FRAME_PIXELS = COLS * ROWS;
  localparam int ADDR_W       = 17;
  localparam int X_W          = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int Y_W          = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int LIN_W        = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;

  localparam logic [X_W-1:0]    X_LAST    = X_W'(COLS - 1);
  localparam logic [Y_W-1:0]    Y_LAST    = Y_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] BANK_BASE = ADDR_W'(BANK_OFFSET);

  typedef enum logic {
    S_IDLE,
    S_WRITE
  } state_e;

  state_e              state_q;
  logic [X_W-1:0]      x_q;
  logic [Y_W-1:0]      y_q;
  logic [LIN_W-1:0]    lin_q;
  // Bank that new writes target; flips on the completing edge so a frame
  // starting on the very next pixel already lands in the other bank.
  logic                wr_bank_q;
  // Externally visible bank lags wr_bank_q by one cycle.
  logic                bank_q;
  logic                pixel_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                write_en_q;
  logic                done_q;
  logic                error_q;

  logic                accept_d;
  logic                restart_d;
  logic                last_pixel_d;
  logic [LIN_W-1:0]    offset_d;
  logic [ADDR_W-1:0]   addr_d;

  // Decode acceptance, frame completion and the address to issue this cycle.
  always_comb begin
    restart_d    = data_valid_in && frame_start_in;
    accept_d     = data_valid_in && (frame_start_in || (state_q == S_WRITE));
    last_pixel_d = (state_q == S_WRITE) && !frame_start_in &&
                   (x_q == X_LAST) && (y_q == Y_LAST);
    offset_d     = restart_d ? '0 : lin_q;
    addr_d       = (wr_bank_q ? BANK_BASE : '0) + ADDR_W'(offset_d);
  end

  // Frame FSM with position counters and registered BRAM-side outputs.
  // NOTE: every register here uses <= so all of them update from the same
  // pre-edge values; blocking assignments would chain updates within a cycle.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      lin_q      <= '0;
      wr_bank_q  <= 1'b0;
      bank_q     <= 1'b0;
      pixel_q    <= 1'b0;
      addr_q     <= '0;
      write_en_q <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      write_en_q <= accept_d;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      bank_q     <= wr_bank_q;

      // Data and address hold their last values between writes.
      if (accept_d) begin
        pixel_q <= pixel_in;
        addr_q  <= addr_d;
      end

      if (accept_d) begin
        if (restart_d) begin
          // A start while already writing aborts the frame; it restarts at
          // (0,0) in the same bank.
          error_q <= (state_q == S_WRITE);
          state_q <= S_WRITE;
          x_q     <= X_W'(1);
          y_q     <= '0;
          lin_q   <= LIN_W'(1);
        end else if (last_pixel_d) begin
          done_q    <= 1'b1;
          state_q   <= S_IDLE;
          x_q       <= '0;
          y_q       <= '0;
          lin_q     <= '0;
          wr_bank_q <= ~wr_bank_q;
        end else begin
          lin_q <= lin_q + LIN_W'(1);
          if (x_q == X_LAST) begin
            x_q <= '0;
            y_q <= y_q + Y_W'(1);
          end else begin
            x_q <= x_q + X_W'(1);
          end
        end
      end
    end
  end

  assign pixel_out       = pixel_q;
  assign pixel_addr_out  = addr_q;
  assign write_en_out    = write_en_q;
  assign bank_out        = bank_q;
  assign frame_done_out  = done_q;
  assign frame_error_out = error_q;

endmodule

// File: tb/tb_rotate2_frame_writer.sv
// Scoreboard bench for rotate2_frame_writer: the driver feeds a pixel-count
// reference model that queues expected writes; a negedge monitor compares.
module tb_rotate2_frame_writer;

  localparam int COLS        = 80;
  localparam int ROWS        = 107;
  localparam int BANK_OFFSET = 16384;
  localparam int FRAME       = COLS * ROWS;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        frame_start_in;
  logic        data_valid_in;
  logic        pixel_in;
  logic        pixel_out;
  logic [16:0] pixel_addr_out;
  logic        write_en_out;
  logic        bank_out;
  logic        frame_done_out;
  logic        frame_error_out;

  rotate2_frame_writer #(
    .COLS(COLS), .ROWS(ROWS), .BANK_OFFSET(BANK_OFFSET)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .frame_start_in(frame_start_in),
    .data_valid_in(data_valid_in),
    .pixel_in(pixel_in),
    .pixel_out(pixel_out),
    .pixel_addr_out(pixel_addr_out),
    .write_en_out(write_en_out),
    .bank_out(bank_out),
    .frame_done_out(frame_done_out),
    .frame_error_out(frame_error_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int   addr;
    logic data;
    logic done;
    logic err;
    logic bank;
  } exp_t;

  exp_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;

  // Reference model: frame position as a plain pixel count.
  bit m_in_frame = 0;
  int m_n        = 0;
  bit m_bank     = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_pixel(input bit fs, input bit p);
    exp_t e;
    if (fs) begin
      e = '{addr: (m_bank ? BANK_OFFSET : 0), data: p, done: 1'b0,
            err: m_in_frame, bank: m_bank};
      exp_q.push_back(e);
      m_in_frame = 1;
      m_n        = 1;
    end else if (m_in_frame) begin
      e = '{addr: (m_bank ? BANK_OFFSET : 0) + m_n, data: p,
            done: (m_n == FRAME - 1), err: 1'b0, bank: m_bank};
      exp_q.push_back(e);
      m_n++;
      if (m_n == FRAME) begin
        m_in_frame = 0;
        m_n        = 0;
        m_bank     = ~m_bank;
      end
    end
  endfunction

  // One clock of stimulus; the model sees exactly what the DUT samples.
  task automatic cycle(input bit r, input bit v, input bit fs, input bit p);
    rst_in         = r;
    data_valid_in  = v;
    frame_start_in = fs;
    pixel_in       = p;
    if (r) begin
      m_in_frame = 0;
      m_n        = 0;
      m_bank     = 0;
    end else if (v) begin
      model_pixel(fs, p);
    end
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
  endtask

  // Frame of npix pixels, first one flagged as frame start.
  task automatic send_frame(input int npix, input bit bubbles, input bit xdata);
    bit p;
    for (int i = 0; i < npix; i++) begin
      if (bubbles)
        while ($urandom_range(3) == 0)
          cycle(0, 0, 1'($urandom_range(1)), 1'($urandom_range(1)));
      p = xdata ? 1'((i % COLS) & 1) : 1'($urandom_range(1));
      cycle(0, 1, (i == 0), p);
    end
  endtask

  // Monitor: pops one expectation per write and checks the bank toggle
  // the cycle after each frame completes.
  bit   bank_chk_pending = 0;
  logic bank_chk_exp     = 0;
  always @(negedge clk_in) begin
    exp_t e;
    if (bank_chk_pending) begin
      check("bank_toggle", 32'(bank_out), 32'(bank_chk_exp));
      bank_chk_pending = 0;
    end
    if (write_en_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(write_en_out), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("addr", 32'(pixel_addr_out), 32'(e.addr));
        check("data", 32'(pixel_out), 32'(e.data));
        check("frame_done", 32'(frame_done_out), 32'(e.done));
        check("frame_error", 32'(frame_error_out), 32'(e.err));
        check("bank_during_write", 32'(bank_out), 32'(e.bank));
        if (e.done) begin
          bank_chk_pending = 1;
          bank_chk_exp     = ~e.bank;
        end
      end
    end else if (rst_in === 1'b0) begin
      check("stray_pulse", 32'({frame_done_out, frame_error_out}), 32'd0);
    end
  end

  initial begin
    rst_in = 1; data_valid_in = 0; frame_start_in = 0; pixel_in = 0;

    // Reset, then idle-state drops.
    cycle(1, 0, 0, 0);
    cycle(1, 1, 1, 1);
    @(negedge clk_in);
    check("rst_pixel", 32'(pixel_out), 32'd0);
    check("rst_addr", 32'(pixel_addr_out), 32'd0);
    check("rst_we", 32'(write_en_out), 32'd0);
    check("rst_bank", 32'(bank_out), 32'd0);
    check("rst_done", 32'(frame_done_out), 32'd0);
    check("rst_error", 32'(frame_error_out), 32'd0);
    for (int i = 0; i < 20; i++) cycle(0, 1, 0, 1'($urandom_range(1)));
    @(negedge clk_in);
    check("idle_we", 32'(write_en_out), 32'd0);
    check("idle_bank", 32'(bank_out), 32'd0);

    // Two back-to-back full frames: bank 0 with x[0] data, then bank 1.
    send_frame(FRAME, 0, 1);
    send_frame(FRAME, 0, 0);
    idle(3);
    @(negedge clk_in);
    check("bank_after_two", 32'(bank_out), 32'd0);

    // Frame with random bubbles (and ignored unqualified frame starts).
    send_frame(FRAME, 1, 0);
    idle(3);
    @(negedge clk_in);
    check("bank_after_bubbles", 32'(bank_out), 32'd1);

    // Reset in the middle of a bank-1 frame, then drops until a new start.
    send_frame(3000, 0, 0);
    cycle(1, 1, 0, 1);
    @(negedge clk_in);
    check("midrst_we", 32'(write_en_out), 32'd0);
    check("midrst_bank", 32'(bank_out), 32'd0);
    for (int i = 0; i < 30; i++) cycle(0, 1, 0, 1'($urandom_range(1)));

    // Early restart at pixel 500 of a bank-0 frame, then a full frame.
    send_frame(500, 0, 1);
    send_frame(FRAME, 0, 1);
    idle(3);
    @(negedge clk_in);
    check("bank_after_restart", 32'(bank_out), 32'd1);

    idle(2);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rotate2_frame_writer.md
Name: rotate2_frame_writer

Overview:
- Write side of the small rotated frame buffer. Takes a 1-bit pixel stream in raster order (valid-qualified, frame-start marked) and produces BRAM write address, data and enable.
- Frames are stored as address = y*COLS + x. The display-side rotating reader fetches them with its (106-h)*80+v address mapping.
- Ping-pong banking: the writer fills one bank while the reader scans the other. Bank ownership swaps only on a completed frame.

Parameters:
- COLS, 80, pixels per source row; also the BRAM row stride.
- ROWS, 107, source rows per frame.
- BANK_OFFSET, 16384, address offset of bank 1. Must be >= COLS*ROWS, and BANK_OFFSET + COLS*ROWS must be <= 2^17.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous, active-high reset
- frame_start_in  input  1  marks the first pixel of a frame; sampled only when data_valid_in=1
- data_valid_in  input  1  pixel_in is valid this cycle
- pixel_in  input  1  pixel data
- pixel_out  output  1  BRAM write data
- pixel_addr_out  output  17  BRAM write address
- write_en_out  output  1  BRAM write enable
- bank_out  output  1  bank currently being written; the reader uses ~bank_out
- frame_done_out  output  1  one-cycle pulse when a full frame has been written
- frame_error_out  output  1  one-cycle pulse when a frame is aborted by an early frame_start

Behaviour:
- Reset (rst_in=1 at a clock edge): state=IDLE, x=0, y=0.
- Outputs after reset: pixel_out=0, pixel_addr_out=0, write_en_out=0, bank_out=0, frame_done_out=0, frame_error_out=0.
- rst_in has priority over all other inputs, including in mid-frame. A partially written frame is discarded and bank_out returns to 0.
- All outputs are registered. Pixel accepted at edge N produces write_en_out=1 with its address and data during cycle N+1 (1-cycle latency).
- A pixel is accepted only when data_valid_in=1 and the FSM state permits it. data_valid_in=0 is a bubble: no write, counters hold.
- FSM IDLE:
  - Valid pixels with frame_start_in=0 are dropped (no write).
  - Valid pixel with frame_start_in=1 is written as pixel (0,0); go to WRITE with x=1, y=0.
- FSM WRITE:
  - Each valid pixel with frame_start_in=0 is written at (x,y).
  - x advances on each accepted pixel. When x=COLS-1, x wraps to 0 and y increments.
- Frame completion: on acceptance of pixel (COLS-1, ROWS-1), the write is issued, then:
  - frame_done_out pulses in the same cycle as that final write_en_out;
  - bank_out toggles one cycle later;
  - state returns to IDLE with x=y=0.
- Early frame_start in WRITE (frame_start_in=1 with valid, frame not complete):
  - frame_error_out pulses in the next cycle.
  - That pixel is written as (0,0) of a new frame in the same bank, with no bank toggle.
  - State stays WRITE with x=1, y=0.
- frame_start_in with data_valid_in=0 is ignored in every state.
- Address: pixel_addr_out = (bank_out ? BANK_OFFSET : 0) + y*COLS + x.
  - Generate it with a running linear counter (reset to 0, +1 per accepted pixel). No multiplier.
  - Bank base is added at issue time.
  - Bank-0 range is 0..COLS*ROWS-1; bank-1 range is BANK_OFFSET..BANK_OFFSET+COLS*ROWS-1.
- Counter widths: x holds COLS-1, y holds ROWS-1, the linear counter holds COLS*ROWS-1. No wrap beyond a frame is possible because completion returns the FSM to IDLE.
- frame_done_out and frame_error_out are never both high in the same cycle.
- While write_en_out=0, pixel_out and pixel_addr_out hold their last values.

Test Plan:
- Reset then idle: rst_in=1 for 2 cycles, then valid pixels with frame_start_in=0 → write_en_out stays 0, bank_out=0, all outputs 0.
- Full frame: frame_start + 8560 contiguous valid pixels with pixel_in=x[0] →
  - 8560 writes at addresses 0..8559 in order, data matches;
  - frame_done_out pulses with address 8559;
  - bank_out=1 next cycle.
- Second frame → addresses 16384..24943; frame_done_out pulses; bank_out returns to 0.
- Bubbles: random data_valid_in=0 gaps inside a frame → same address/data sequence with no duplicates or skips; write_en_out high exactly once per valid pixel.
- Early restart: frame_start at pixel 500 of a bank-0 frame →
  - frame_error_out pulses once;
  - that pixel is written at address 0;
  - bank_out stays 0;
  - a following 8559 pixels complete the frame with frame_done_out.
- Reset mid-frame: rst_in at pixel 3000 of a bank-1 frame → write_en_out=0 and bank_out=0 next cycle; valid pixels without frame_start are dropped until the next frame_start.
